// File: rtl/scoreboard_display_ctrl.sv
// Scoreboard display sequencer: rotates "P1"/A/"P2"/B views on a dual 7-segment driver,
// converts binary scores to BCD by repeated subtraction, and blinks a score that just changed.
module scoreboard_display_ctrl #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLINK_CYCLES = 250,
    parameter int BLINK_COUNT  = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ena_i,
    input  logic [6:0] score_a_i,
    input  logic [6:0] score_b_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       team_o,
    output logic       busy_o
);
    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int PW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] PHASE_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [PW-1:0] PAIR_LAST  = PW'(BLINK_COUNT - 1);

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_P     = 4'd11;
    localparam logic [3:0] CODE_ERR   = 4'd15;

    typedef enum logic [2:0] {S_IDLE, S_LABEL, S_CONV, S_SHOW, S_BLINK} state_t;

    state_t        state, state_n;
    logic          team, team_n;
    logic [DW-1:0] dwell_cnt, dwell_n;
    logic [BW-1:0] phase_cnt, phase_n;
    logic [PW-1:0] pair_cnt, pair_n;
    logic          blink_on, on_n;
    logic          blink_mode, mode_n;
    logic [6:0]    tmp, tmp_n;
    logic [3:0]    tens, tens_n;
    logic          err, err_n;
    logic [6:0]    last_a, last_b;
    logic          pend_a, pend_a_n, pend_b, pend_b_n;
    logic [3:0]    tens_o_n, ones_o_n, dig_tens, dig_ones;

    logic start_conv, conv_team, conv_blink, pend_cur;

    assign pend_cur = team ? pend_b : pend_a;

    always_comb begin
        // NOTE: every combinational target is defaulted first so no path infers a latch.
        state_n    = state;
        team_n     = team;
        dwell_n    = dwell_cnt;
        phase_n    = phase_cnt;
        pair_n     = pair_cnt;
        on_n       = blink_on;
        mode_n     = blink_mode;
        tmp_n      = tmp;
        tens_n     = tens;
        err_n      = err;
        start_conv = 1'b0;
        conv_team  = team;
        conv_blink = 1'b0;

        if (!ena_i) begin
            state_n = S_IDLE;
            team_n  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_LABEL;
                    team_n  = 1'b0;
                    dwell_n = '0;
                end
                S_LABEL, S_SHOW: begin
                    if (pend_a || pend_b) begin
                        start_conv = 1'b1;
                        conv_team  = !pend_a;
                        conv_blink = 1'b1;
                    end else if (dwell_cnt != DWELL_LAST) begin
                        dwell_n = dwell_cnt + 1'b1;
                    end else if (state == S_LABEL) begin
                        start_conv = 1'b1;
                    end else begin
                        state_n = S_LABEL;
                        team_n  = !team;
                        dwell_n = '0;
                    end
                end
                S_CONV: begin
                    if (!err && tmp >= 7'd10) begin
                        tmp_n  = tmp - 7'd10;
                        tens_n = tens + 4'd1;
                    end else if (pend_cur) begin
                        start_conv = 1'b1;
                        conv_blink = 1'b1;
                    end else if (blink_mode) begin
                        state_n = S_BLINK;
                        phase_n = '0;
                        pair_n  = '0;
                        on_n    = 1'b0;
                    end else begin
                        state_n = S_SHOW;
                        dwell_n = '0;
                    end
                end
                S_BLINK: begin
                    if (phase_cnt != PHASE_LAST) begin
                        phase_n = phase_cnt + 1'b1;
                    end else if (pend_cur) begin
                        start_conv = 1'b1;
                        conv_blink = 1'b1;
                    end else if (blink_on && pair_cnt == PAIR_LAST) begin
                        if (pend_a || pend_b) begin
                            start_conv = 1'b1;
                            conv_team  = !pend_a;
                            conv_blink = 1'b1;
                        end else begin
                            state_n = S_SHOW;
                            dwell_n = '0;
                        end
                    end else begin
                        phase_n = '0;
                        on_n    = !blink_on;
                        pair_n  = pair_cnt + PW'(blink_on);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        if (start_conv) begin
            state_n = S_CONV;
            team_n  = conv_team;
            mode_n  = conv_blink;
            tmp_n   = conv_team ? score_b_i : score_a_i;
            tens_n  = 4'd0;
            err_n   = tmp_n > 7'd99;
        end

        // A new change outranks the serve that clears the flag in the same cycle.
        pend_a_n = pend_a && !(start_conv && !conv_team);
        pend_b_n = pend_b && !(start_conv && conv_team);
        if (score_a_i != last_a) pend_a_n = 1'b1;
        if (score_b_i != last_b) pend_b_n = 1'b1;
        if (!ena_i || state == S_IDLE) begin
            pend_a_n = 1'b0;
            pend_b_n = 1'b0;
        end

        dig_tens = err_n ? CODE_ERR : ((tens_n == 4'd0) ? CODE_BLANK : tens_n);
        dig_ones = err_n ? CODE_ERR : tmp_n[3:0];
        tens_o_n = CODE_BLANK;
        ones_o_n = CODE_BLANK;
        case (state_n)
            S_LABEL: begin
                tens_o_n = CODE_P;
                ones_o_n = team_n ? 4'd2 : 4'd1;
            end
            S_SHOW: begin
                tens_o_n = dig_tens;
                ones_o_n = dig_ones;
            end
            S_BLINK: if (on_n) begin
                tens_o_n = dig_tens;
                ones_o_n = dig_ones;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            team       <= 1'b0;
            dwell_cnt  <= '0;
            phase_cnt  <= '0;
            pair_cnt   <= '0;
            blink_on   <= 1'b0;
            blink_mode <= 1'b0;
            tmp        <= '0;
            tens       <= '0;
            err        <= 1'b0;
            last_a     <= '0;
            last_b     <= '0;
            pend_a     <= 1'b0;
            pend_b     <= 1'b0;
            tens_o     <= CODE_BLANK;
            ones_o     <= CODE_BLANK;
            team_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state      <= state_n;
            team       <= team_n;
            dwell_cnt  <= dwell_n;
            phase_cnt  <= phase_n;
            pair_cnt   <= pair_n;
            blink_on   <= on_n;
            blink_mode <= mode_n;
            tmp        <= tmp_n;
            tens       <= tens_n;
            err        <= err_n;
            last_a     <= score_a_i;
            last_b     <= score_b_i;
            pend_a     <= pend_a_n;
            pend_b     <= pend_b_n;
            tens_o     <= tens_o_n;
            ones_o     <= ones_o_n;
            team_o     <= team_n;
            busy_o     <= (state_n == S_CONV);
        end
    end
endmodule

// File: tb/tb_scoreboard_display_ctrl.sv
// Directed bench for scoreboard_display_ctrl: each task plays a table of expected output
// segments (value, run length) with optional input changes applied after a segment ends.
module tb_scoreboard_display_ctrl;
    localparam int DWELL = 4;
    localparam int BLINK = 2;
    localparam int COUNT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [6:0] sa, sb;
    logic [3:0] tens, ones;
    logic       team, busy;

    int checks = 0;
    int errors = 0;

    // pa/pb/pe: new score A / score B / ena applied after the segment's last cycle (-1 = none)
    typedef struct {
        int t; int o; int n; int tm; int b; int pa; int pb; int pe;
    } seg_t;
    seg_t exp_q[$];

    always #5 clk = ~clk;

    scoreboard_display_ctrl #(
        .DWELL_CYCLES(DWELL),
        .BLINK_CYCLES(BLINK),
        .BLINK_COUNT (COUNT)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .ena_i    (ena),
        .score_a_i(sa),
        .score_b_i(sb),
        .tens_o   (tens),
        .ones_o   (ones),
        .team_o   (team),
        .busy_o   (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int t, input int o, input int n, input int tm, input int b);
        seg_t s;
        s.t = t; s.o = o; s.n = n; s.tm = tm; s.b = b;
        s.pa = -1; s.pb = -1; s.pe = -1;
        exp_q.push_back(s);
    endtask

    task automatic poke(input int pa, input int pb, input int pe);
        exp_q[exp_q.size()-1].pa = pa;
        exp_q[exp_q.size()-1].pb = pb;
        exp_q[exp_q.size()-1].pe = pe;
    endtask

    // Reset with the given scores, then raise ena so the next edge enters the "P1" label.
    task automatic start(input logic [6:0] a, input logic [6:0] b);
        rst_n = 1'b0;
        ena   = 1'b0;
        sa    = a;
        sb    = b;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        ena = 1'b1;
        exp_q.delete();
    endtask

    // Common front of most scenarios: A=7 view, then first cycle of the "P2" label.
    task automatic add_to_b_label();
        add(11, 1, DWELL, 0, 0);
        add(10, 10, 1, 0, 1);
        add(10, 7, DWELL, 0, 0);
        add(11, 2, 1, 1, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b0;
        sa    = 7'd0;
        sb    = 7'd0;
        step();
        checks++;
        if (tens !== 4'd10) begin errors++; $display("FAIL reset_tens: got %0d want 10", tens); end
        checks++;
        if (ones !== 4'd10) begin errors++; $display("FAIL reset_ones: got %0d want 10", ones); end
        checks++;
        if (team !== 1'b0) begin errors++; $display("FAIL reset_team: got %0d want 0", team); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d want 0", busy); end
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (tens !== 4'd10 || ones !== 4'd10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_disabled: got %0d/%0d busy=%0d want 10/10 busy=0", tens, ones, busy);
        end
    endtask

    task automatic test_rotation();
        start(7'd7, 7'd42);
        add(11, 1, DWELL, 0, 0);
        add(10, 10, 1, 0, 1);
        add(10, 7, DWELL, 0, 0);
        add(11, 2, DWELL, 1, 0);
        add(10, 10, 5, 1, 1);
        add(4, 2, DWELL, 1, 0);
        add(11, 1, DWELL, 0, 0);
        foreach (exp_q[i]) begin
            for (int k = 0; k < exp_q[i].n; k++) begin
                step();
                checks++;
                if (tens !== 4'(exp_q[i].t) || ones !== 4'(exp_q[i].o) ||
                    team !== (exp_q[i].tm != 0) || busy !== (exp_q[i].b != 0)) begin
                    errors++;
                    $display("FAIL rotation seg%0d cyc%0d: got %0d/%0d team=%0d busy=%0d want %0d/%0d team=%0d busy=%0d",
                             i, k, tens, ones, team, busy, exp_q[i].t, exp_q[i].o, exp_q[i].tm, exp_q[i].b);
                end
            end
        end
    endtask

    task automatic test_boundaries();
        int sc[4]   = '{0, 99, 100, 10};
        int conv[4] = '{1, 10, 1, 2};
        int et[4]   = '{10, 9, 15, 1};
        int eo[4]   = '{0, 9, 15, 0};
        for (int j = 0; j < 4; j++) begin
            start(7'(sc[j]), 7'd42);
            add(11, 1, DWELL, 0, 0);
            add(10, 10, conv[j], 0, 1);
            add(et[j], eo[j], DWELL, 0, 0);
            add(11, 2, 1, 1, 0);
            foreach (exp_q[i]) begin
                for (int k = 0; k < exp_q[i].n; k++) begin
                    step();
                    checks++;
                    if (tens !== 4'(exp_q[i].t) || ones !== 4'(exp_q[i].o) ||
                        team !== (exp_q[i].tm != 0) || busy !== (exp_q[i].b != 0)) begin
                        errors++;
                        $display("FAIL boundary_a%0d seg%0d cyc%0d: got %0d/%0d team=%0d busy=%0d want %0d/%0d team=%0d busy=%0d",
                                 sc[j], i, k, tens, ones, team, busy, exp_q[i].t, exp_q[i].o, exp_q[i].tm, exp_q[i].b);
                    end
                end
            end
        end
    endtask

    task automatic test_blink();
        start(7'd7, 7'd42);
        add_to_b_label();
        poke(8, -1, -1);
        add(11, 2, 1, 1, 0);
        add(10, 10, 1, 0, 1);
        for (int p = 0; p < COUNT; p++) begin
            add(10, 10, BLINK, 0, 0);
            add(10, 8, BLINK, 0, 0);
        end
        add(10, 8, DWELL, 0, 0);
        add(11, 2, DWELL, 1, 0);
        foreach (exp_q[i]) begin
            for (int k = 0; k < exp_q[i].n; k++) begin
                step();
                checks++;
                if (tens !== 4'(exp_q[i].t) || ones !== 4'(exp_q[i].o) ||
                    team !== (exp_q[i].tm != 0) || busy !== (exp_q[i].b != 0)) begin
                    errors++;
                    $display("FAIL blink seg%0d cyc%0d: got %0d/%0d team=%0d busy=%0d want %0d/%0d team=%0d busy=%0d",
                             i, k, tens, ones, team, busy, exp_q[i].t, exp_q[i].o, exp_q[i].tm, exp_q[i].b);
                end
            end
            if (exp_q[i].pa >= 0) sa = 7'(exp_q[i].pa);
            if (exp_q[i].pb >= 0) sb = 7'(exp_q[i].pb);
        end
    endtask

    task automatic test_dual_change();
        start(7'd7, 7'd42);
        add_to_b_label();
        poke(8, 43, -1);
        add(11, 2, 1, 1, 0);
        add(10, 10, 1, 0, 1);
        for (int p = 0; p < COUNT; p++) begin
            add(10, 10, BLINK, 0, 0);
            add(10, 8, BLINK, 0, 0);
        end
        add(10, 10, 5, 1, 1);
        for (int p = 0; p < COUNT; p++) begin
            add(10, 10, BLINK, 1, 0);
            add(4, 3, BLINK, 1, 0);
        end
        add(4, 3, DWELL, 1, 0);
        add(11, 1, DWELL, 0, 0);
        add(10, 10, 1, 0, 1);
        add(10, 8, DWELL, 0, 0);
        foreach (exp_q[i]) begin
            for (int k = 0; k < exp_q[i].n; k++) begin
                step();
                checks++;
                if (tens !== 4'(exp_q[i].t) || ones !== 4'(exp_q[i].o) ||
                    team !== (exp_q[i].tm != 0) || busy !== (exp_q[i].b != 0)) begin
                    errors++;
                    $display("FAIL dual_change seg%0d cyc%0d: got %0d/%0d team=%0d busy=%0d want %0d/%0d team=%0d busy=%0d",
                             i, k, tens, ones, team, busy, exp_q[i].t, exp_q[i].o, exp_q[i].tm, exp_q[i].b);
                end
            end
            if (exp_q[i].pa >= 0) sa = 7'(exp_q[i].pa);
            if (exp_q[i].pb >= 0) sb = 7'(exp_q[i].pb);
        end
    endtask

    task automatic test_reblink();
        start(7'd7, 7'd42);
        add_to_b_label();
        poke(8, -1, -1);
        add(11, 2, 1, 1, 0);
        add(10, 10, 1, 0, 1);
        add(10, 10, BLINK, 0, 0);
        add(10, 8, 1, 0, 0);
        poke(9, -1, -1);
        add(10, 8, 1, 0, 0);
        add(10, 10, 1, 0, 1);
        for (int p = 0; p < COUNT; p++) begin
            add(10, 10, BLINK, 0, 0);
            add(10, 9, BLINK, 0, 0);
        end
        add(10, 9, DWELL, 0, 0);
        add(11, 2, 1, 1, 0);
        foreach (exp_q[i]) begin
            for (int k = 0; k < exp_q[i].n; k++) begin
                step();
                checks++;
                if (tens !== 4'(exp_q[i].t) || ones !== 4'(exp_q[i].o) ||
                    team !== (exp_q[i].tm != 0) || busy !== (exp_q[i].b != 0)) begin
                    errors++;
                    $display("FAIL reblink seg%0d cyc%0d: got %0d/%0d team=%0d busy=%0d want %0d/%0d team=%0d busy=%0d",
                             i, k, tens, ones, team, busy, exp_q[i].t, exp_q[i].o, exp_q[i].tm, exp_q[i].b);
                end
            end
            if (exp_q[i].pa >= 0) sa = 7'(exp_q[i].pa);
        end
    endtask

    task automatic test_reset_mid_conv();
        start(7'd7, 7'd42);
        repeat (13) step();
        step();
        step();
        checks++;
        if (busy !== 1'b1 || team !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_conv: got busy=%0d team=%0d want busy=1 team=1", busy, team);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tens !== 4'd10 || ones !== 4'd10 || team !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %0d/%0d team=%0d busy=%0d want 10/10 team=0 busy=0",
                     tens, ones, team, busy);
        end
        ena = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (tens !== 4'd10 || ones !== 4'd10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %0d/%0d busy=%0d want 10/10 busy=0", tens, ones, busy);
        end
        ena = 1'b1;
        step();
        checks++;
        if (tens !== 4'd11 || ones !== 4'd1 || team !== 1'b0) begin
            errors++;
            $display("FAIL restart_label: got %0d/%0d team=%0d want 11/1 team=0", tens, ones, team);
        end
    endtask

    task automatic test_ena_drop();
        start(7'd7, 7'd42);
        add(11, 1, DWELL, 0, 0);
        add(10, 10, 1, 0, 1);
        add(10, 7, 2, 0, 0);
        poke(3, -1, 0);
        add(10, 10, 2, 0, 0);
        poke(-1, -1, 1);
        add(11, 1, DWELL, 0, 0);
        add(10, 10, 1, 0, 1);
        add(10, 3, DWELL, 0, 0);
        add(11, 2, 1, 1, 0);
        foreach (exp_q[i]) begin
            for (int k = 0; k < exp_q[i].n; k++) begin
                step();
                checks++;
                if (tens !== 4'(exp_q[i].t) || ones !== 4'(exp_q[i].o) ||
                    team !== (exp_q[i].tm != 0) || busy !== (exp_q[i].b != 0)) begin
                    errors++;
                    $display("FAIL ena_drop seg%0d cyc%0d: got %0d/%0d team=%0d busy=%0d want %0d/%0d team=%0d busy=%0d",
                             i, k, tens, ones, team, busy, exp_q[i].t, exp_q[i].o, exp_q[i].tm, exp_q[i].b);
                end
            end
            if (exp_q[i].pa >= 0) sa = 7'(exp_q[i].pa);
            if (exp_q[i].pe >= 0) ena = (exp_q[i].pe != 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        sa    = 7'd0;
        sb    = 7'd0;
        test_reset();
        test_rotation();
        test_boundaries();
        test_blink();
        test_dual_change();
        test_reblink();
        test_reset_mid_conv();
        test_ena_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/scoreboard_display_ctrl.md
# scoreboard_display_ctrl

Display sequencer for the scoreboard. It takes two binary team scores and drives the two-digit BCD/code inputs of the dual 7-segment driver. It rotates through label and score views ("P1", score A, "P2", score B), converts each score to tens/ones with a sequential subtract-by-ten loop, and blanks a leading zero. When a score changes, it interrupts the rotation and blinks the new score.

## Interface
- DWELL_CYCLES, default 1000: cycles each label or score view is held (≥2).
- BLINK_CYCLES, default 250: half-period of the blink, in cycles (≥1).
- BLINK_COUNT, default 3: number of off/on blink pairs after a score change (≥1).
- clk_i, input, 1: system clock.
- rst_n_i, input, 1: reset, asynchronous, active-low.
- ena_i, input, 1: display enable. Low means blank display and FSM held in IDLE.
- score_a_i, input, 7: team A score, binary 0..127.
- score_b_i, input, 7: team B score, binary 0..127.
- tens_o, output, 4: code to the tens digit of the driver.
- ones_o, output, 4: code to the ones digit of the driver.
- team_o, output, 1: team currently shown (0 = A, 1 = B).
- busy_o, output, 1: high while in CONV.

## Operation
- Output codes:
  - 0..9 are digits.
  - 10 is blank.
  - 11 is 'P'.
  - 15 is '-' (error).
- States: IDLE, LABEL, CONV, SHOW, BLINK. Registers: team, dwell counter, blink counter, tmp[6:0], tens count, last_a, last_b, pend_a, pend_b.
- IDLE:
  - Outputs are 10/10.
  - last_a/last_b load score_a_i/score_b_i every cycle; pend flags clear.
  - When ena_i=1, go to LABEL with team=0.
- LABEL: outputs 11 / (team ? 2 : 1). Hold DWELL_CYCLES cycles, then go to CONV.
- CONV:
  - On entry, tmp takes the current score of the selected team and tens clears; outputs are 10/10.
  - Each cycle: if tmp ≥ 10, then tmp -= 10 and tens += 1; otherwise exit.
  - Score > 99: exit after 1 cycle with the error flag set.
- SHOW:
  - Outputs are tens/tmp.
  - tens = 0 gives tens_o = 10 (leading-zero blank). Score 0 shows blank/0.
  - Error shows 15/15.
  - Hold DWELL_CYCLES cycles, then go to LABEL with team toggled.
- Change detect: active in every state except IDLE.
  - score_a_i ≠ last_a sets pend_a and updates last_a. Same for B.
- Pending service:
  - At the next cycle boundary of LABEL or SHOW, a pending team is served immediately.
  - If pend_a is set, A is served first; otherwise B.
  - Serving: clear that pend flag, set team, go to CONV, then BLINK instead of SHOW.
- BLINK:
  - Alternates off (10/10) and on (converted digits), each phase BLINK_CYCLES cycles, starting with off.
  - After BLINK_COUNT off/on pairs, continue as SHOW with a fresh DWELL_CYCLES dwell.
- Pending during CONV or BLINK:
  - For the same team: finish the current phase, then re-enter CONV (restarting the blink).
  - For the other team: served after the blink completes, before the SHOW dwell.
- ena_i low in any state: go to IDLE on the next edge. Outputs are 10/10 from that edge.

## Timing
- All outputs are registered. An output reflects the state entered on the same edge.
- Reset (asynchronous, rst_n_i=0) sets:
  - state = IDLE;
  - tens_o = 10, ones_o = 10, team_o = 0, busy_o = 0;
  - all counters, tmp, last_a, last_b and pend flags to 0.
- ena_i 0→1 at edge N: LABEL outputs (11/1) appear at edge N+1.
- CONV latency is floor(score/10)+1 cycles for scores ≤ 99, and 1 cycle for > 99.
  - Example: score 47 gives 5 cycles of CONV, with busy_o=1 exactly those cycles.
- View lengths are exactly DWELL_CYCLES cycles per LABEL and per SHOW.
- A full rotation is 4·DWELL_CYCLES + both CONV latencies.
- Change detection costs 1 cycle: an input change at edge N sets pend at N+1.
- Score-change latency to CONV is at most 2 cycles from LABEL or SHOW.
- A score change in the same cycle that ena_i falls is discarded. IDLE reloads last_*.
- Reset mid-CONV or mid-BLINK drops all state; no partial digits are shown after reset.

## Test plan
- Reset, then ena_i=1 with A=7, B=42, DWELL=4: the sequence is 11/1 ×4, 10/10 ×1 (CONV), 10/7 ×4, 11/2 ×4, 10/10 ×5, 4/2 ×4, then repeats.
- Boundary scores:
  - A=0 gives 10/0.
  - A=99 gives 9/9 after 10 CONV cycles.
  - A=100 gives 15/15 after 1 CONV cycle.
  - A=10 gives 1/0.
- During the B label, A changes 7→8 (BLINK_CYCLES=2, BLINK_COUNT=3): within 2 cycles CONV for A, then 10/10, 10/8 alternating ×2 cycles each (3 pairs), then 10/8 for DWELL, then the 11/2 label.
- A and B change in the same cycle: A blinks first, then B blinks, with no SHOW dwell in between. pend_a and pend_b are both cleared afterwards.
- Score A changes again mid-blink: the current phase finishes, CONV re-runs with the new value, and the blink count restarts at 3.
- Stimulus and response:
  - rst_n_i pulsed low mid-CONV: outputs go to 10/10, team_o=0, busy_o=0 immediately (asynchronously).
  - ena_i dropped mid-SHOW: 10/10 from the next edge.
  - ena_i re-raised: the sequence restarts at 11/1.
